raminfr: RTL and testbench
==========================

RAMINFR -- requirements
Module: raminfr

Interface
REQ-001 The block SHALL have parameter addr_width, default 4, address (pointer) width in bits, positional order 1.
REQ-002 The block SHALL have parameter data_width, default 8, word width in bits, positional order 2.
REQ-003 The block SHALL have parameter depth, default 16, number of words, positional order 3; depth ≤ 2^addr_width.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all logic acts on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, reset; asynchronous, active-low.
REQ-006 The block SHALL have port we, input, 1 bit, write enable, active high.
REQ-007 The block SHALL have port top, input, addr_width bits, write address.
REQ-008 The block SHALL have port bottom, input, addr_width bits, read address.
REQ-009 The block SHALL have port dat_i, input, data_width bits, write data.
REQ-010 The block SHALL have port dat_o, output, data_width bits, read data.

Function
REQ-011 The block SHALL implement a simple dual-port memory of depth words × data_width bits, inferable as distributed RAM.
REQ-012 On a clk rising edge with we=1 and rst_n=1, the block SHALL write dat_i to word[top]; with we=0 the memory SHALL be unchanged.
REQ-013 A write with top ≥ depth SHALL be ignored; no other word is modified.
REQ-014 Writes SHALL be inhibited while rst_n=0.
REQ-015 Default (macro absent): dat_o SHALL equal word[bottom] combinationally, with zero-cycle latency from a bottom change.
REQ-016 If bottom ≥ depth, dat_o SHALL be all zeros.
REQ-017 Simultaneous read and write to the same address: dat_o SHALL show the old word before the edge and the new word immediately after it.
REQ-018 All memory words SHALL initialise to zero at time zero.
REQ-019 rst_n SHALL NOT clear memory contents, so that RAM inference is preserved.
REQ-020 Address arithmetic SHALL be unsigned; pointer wrap-around is the caller's responsibility.

Reset
REQ-021 Default mode: rst_n SHALL affect only write inhibition; dat_o continues to reflect word[bottom].
REQ-022 Registered mode: rst_n=0 SHALL asynchronously force dat_o to 0, held until the first rising edge after release.
REQ-023 Assertion of rst_n mid-operation SHALL drop any write on that edge; previously written data SHALL be retained.

Configuration
REQ-024 Macro RAMINFR_REG_OUT_EN, when defined, SHALL add an output register: at each rising edge, dat_o <= word[bottom], giving one-cycle read latency.
REQ-025 In registered mode, a read and write to the same address on one edge SHALL return the old word (read-before-write); the new word appears one edge later.
REQ-026 Without RAMINFR_REG_OUT_EN, the read path SHALL be purely combinational as in REQ-015.

Verification
REQ-027 Basic write/read: write 0xA5 to address 3, then set bottom=3 -> dat_o=0xA5 (default mode, same cycle); registered mode shows 0xA5 after 1 edge.
REQ-028 Full sweep: write value (addr ^ 0x5A) to addresses 0..15, read back all 16 addresses -> every word matches; an unwritten fresh instance reads 0x00.
REQ-029 Same-address collision: word[7]=0x11, write 0x22 to 7 with bottom=7 -> default mode shows 0x11 before the edge and 0x22 after; registered mode shows 0x11 after edge 1 and 0x22 after edge 2.
REQ-030 Write-enable gating: we=0, dat_i=0xFF, top=2 for 5 edges -> word[2] unchanged.
REQ-031 Reset mid-operation: word[4]=0x3C, assert rst_n=0 with we=1, top=4, dat_i=0x99 -> word[4] stays 0x3C; registered mode drives dat_o=0x00 immediately.
REQ-032 Out-of-range: depth=12, write 0x77 to top=13 -> no word changes; bottom=13 -> dat_o=0x00.

Source files
------------

// File: rtl/raminfr.sv
// raminfr: simple dual-port RAM, inferable as distributed RAM.
//
// One synchronous write port (we/top/dat_i) and one read port (bottom/dat_o).
// Memory words power up as zero. rst_n never clears the array. While rst_n is
// low, writes are blocked.
//
// Configuration macro:
//   RAMINFR_REG_OUT_EN  undefined (default): dat_o = word[bottom], combinational.
//                       defined: dat_o is registered with one-cycle latency and
//                       read-before-write behaviour. rst_n low clears it
//                       asynchronously.
//
// Parameters: addr_width (pointer width), data_width (word width),
//             depth (number of words, depth <= 2**addr_width).
// Ports:
//   clk     in   clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   we      in   write enable
//   top     in   write address
//   bottom  in   read address
//   dat_i   in   write data
//   dat_o   out  read data (zero when bottom >= depth)
module raminfr #(
  parameter int unsigned addr_width = 4,
  parameter int unsigned data_width = 8,
  parameter int unsigned depth      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [addr_width-1:0] top,
  input  logic [addr_width-1:0] bottom,
  input  logic [data_width-1:0] dat_i,
  output logic [data_width-1:0] dat_o
);

  localparam int unsigned IdxW = (depth > 1) ? $clog2(depth) : 1;

  // Power-up contents are zero. A declaration initialiser keeps the array free of
  // any reset term, so the tools can still infer distributed RAM.
  logic [data_width-1:0] mem [depth] = '{default: '0};

  logic                  wr_en;
  logic                  rd_in_range;
  logic [data_width-1:0] rd_word;

  assign wr_en       = we && rst_n && (32'(top) < depth);
  assign rd_in_range = 32'(bottom) < depth;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[top[IdxW-1:0]] <= dat_i;
    end
  end

  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[bottom[IdxW-1:0]];
    end
  end

`ifdef RAMINFR_REG_OUT_EN
  logic [data_width-1:0] dat_q;

  // The register samples the array before this edge's write lands, so a
  // same-address read returns the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat_q <= '0;
    end else begin
      dat_q <= rd_word;
    end
  end

  assign dat_o = dat_q;
`else
  assign dat_o = rd_word;
`endif

endmodule

// File: tb/tb_raminfr.sv
// Testbench for raminfr. It drives two instances from the same inputs: one
// with depth 16 and one with depth 12, so out-of-range addresses can be
// tested. Both outputs are checked against an array model of the memory.
// The bench follows RAMINFR_REG_OUT_EN, so it covers both read modes.
module tb_raminfr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       we;
  logic [3:0] top;
  logic [3:0] bottom;
  logic [7:0] dat_i;
  logic [7:0] dat_a;
  logic [7:0] dat_b;

  int errors = 0;
  int checks = 0;

  // Reference memories: what each word should hold.
  logic [7:0] m_a [16];
  logic [7:0] m_b [16];
  // Expected registered-output values (used only in registered mode).
  logic [7:0] q_a;
  logic [7:0] q_b;

  always #5 clk = ~clk;

  raminfr #(.addr_width(4), .data_width(8), .depth(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .we(we), .top(top), .bottom(bottom),
    .dat_i(dat_i), .dat_o(dat_a)
  );

  raminfr #(.addr_width(4), .data_width(8), .depth(12)) dut_b (
    .clk(clk), .rst_n(rst_n), .we(we), .top(top), .bottom(bottom),
    .dat_i(dat_i), .dat_o(dat_b)
  );

  function automatic logic [7:0] rd_a(input logic [3:0] a);
    return m_a[a];
  endfunction

  function automatic logic [7:0] rd_b(input logic [3:0] a);
    return (int'(a) < 12) ? m_b[a] : 8'h00;
  endfunction

  function automatic logic [7:0] exp_a();
`ifdef RAMINFR_REG_OUT_EN
    return q_a;
`else
    return rd_a(bottom);
`endif
  endfunction

  function automatic logic [7:0] exp_b();
`ifdef RAMINFR_REG_OUT_EN
    return q_b;
`else
    return rd_b(bottom);
`endif
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_both(input string tag);
    check({tag, "_a"}, dat_a, exp_a());
    check({tag, "_b"}, dat_b, exp_b());
  endtask

  // One rising edge. Update the model from the inputs applied at that edge,
  // then wait a little past the edge so outputs can be sampled.
  task automatic tick();
    @(posedge clk);
    q_a = rst_n ? rd_a(bottom) : 8'h00;
    q_b = rst_n ? rd_b(bottom) : 8'h00;
    if (we && rst_n) begin
      m_a[top] = dat_i;
      if (int'(top) < 12) m_b[top] = dat_i;
    end
    #1;
  endtask

  task automatic write(input logic [3:0] a, input logic [7:0] d);
    we = 1'b1; top = a; dat_i = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      m_a[i] = 8'h00;
      m_b[i] = 8'h00;
    end
    q_a = 8'h00; q_b = 8'h00;
    rst_n = 1'b0; we = 1'b0; top = '0; bottom = '0; dat_i = '0;
    #1;
    check_both("reset");
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // A fresh instance reads zero everywhere.
    for (int i = 0; i < 16; i++) begin
      bottom = 4'(i);
      tick();
      check_both("fresh");
    end

    // Basic write then read.
    write(4'd3, 8'hA5);
    bottom = 4'd3;
`ifndef RAMINFR_REG_OUT_EN
    #1;
    check_both("basic_comb");
`endif
    tick();
    check_both("basic");

    // Full sweep of addr ^ 0x5A, then read every address back.
    for (int i = 0; i < 16; i++) write(4'(i), 8'(i) ^ 8'h5A);
    for (int i = 0; i < 16; i++) begin
      bottom = 4'(i);
      tick();
      check_both("sweep");
    end

    // Same-address collision.
    write(4'd7, 8'h11);
    we = 1'b1; top = 4'd7; dat_i = 8'h22; bottom = 4'd7;
    #1;
`ifndef RAMINFR_REG_OUT_EN
    check("collide_pre", dat_a, 8'h11);
`endif
    tick();
    we = 1'b0;
`ifdef RAMINFR_REG_OUT_EN
    check("collide_e1", dat_a, 8'h11);
`else
    check("collide_e1", dat_a, 8'h22);
`endif
    tick();
    check("collide_e2", dat_a, 8'h22);

    // With write enable low, the memory must not change.
    we = 1'b0; top = 4'd2; dat_i = 8'hFF;
    repeat (5) tick();
    bottom = 4'd2;
    tick();
    check_both("we_gate");
    check("we_gate_abs", dat_a, 8'h02 ^ 8'h5A);

    // Reset in the middle of operation.
    write(4'd4, 8'h3C);
    bottom = 4'd4;
    tick();
    we = 1'b1; top = 4'd4; dat_i = 8'h99; rst_n = 1'b0;
    q_a = 8'h00; q_b = 8'h00;
    #1;
    check_both("rst_async");
    tick();
    check_both("rst_hold");
    rst_n = 1'b1; we = 1'b0;
    tick();
    check_both("rst_release");
    check("rst_keep", dat_a, 8'h3C);

    // Out-of-range write and read on the depth-12 instance.
    write(4'd13, 8'h77);
    bottom = 4'd13;
    tick();
    check("oor_read", dat_b, 8'h00);
    for (int i = 0; i < 12; i++) begin
      bottom = 4'(i);
      tick();
      check("oor_keep", dat_b, exp_b());
    end

    // Random traffic checked against the model.
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1));
      top = 4'($urandom_range(0, 15));
      bottom = 4'($urandom_range(0, 15));
      dat_i = 8'($urandom);
`ifndef RAMINFR_REG_OUT_EN
      #1;
      check_both("rand_pre");
`endif
      tick();
      check_both("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
